// File: rtl/cdc_handshake_rx_if.sv
// Bundle for the receive side of a toggle req/ack crossing: the remote sender's
// req/data/ack plus the local valid/ready delivery and status outputs.
interface cdc_handshake_rx_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 req_async;
    logic [WIDTH-1:0]     data_async;
    logic                 ack_toggle;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err_unstable;
    logic                 err_overrun;
    logic [CNT_WIDTH-1:0] xfer_count;

    // The master side is the sender together with the local consumer.
    modport master (
        output req_async, data_async, out_ready,
        input  ack_toggle, out_data, out_valid, err_unstable, err_overrun, xfer_count
    );

    modport slave (
        input  req_async, data_async, out_ready,
        output ack_toggle, out_data, out_valid, err_unstable, err_overrun, xfer_count
    );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Destination-domain controller for a toggle req/ack multi-bit crossing: synchronises
// the request toggle, qualifies the quasi-static data, delivers it and returns an ack toggle.
module cdc_handshake_rx #(
    parameter int SYNC_DEPTH    = 2,
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_WIDTH     = 16
) (
    input logic              clk,
    input logic              rst,
    cdc_handshake_rx_if.slave bus
);
    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [SYNC_DEPTH-1:0] syncChain_q;
    logic                 reqSyncDly_q;
    logic                 reqPrev_q, reqPrev_d;
    logic [WIDTH-1:0]     data_q;
    logic [WIDTH-1:0]     sample_q, sample_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     outData_q, outData_d;
    logic                 outValid_q, outValid_d;
    logic                 ackToggle_q, ackToggle_d;
    logic                 errUnstable_q, errUnstable_d;
    logic                 errOverrun_q, errOverrun_d;
    logic [CNT_WIDTH-1:0] xferCount_q, xferCount_d;

    logic reqSync;
    logic reqEdge;

    assign reqSync = syncChain_q[SYNC_DEPTH-1];
    assign reqEdge = reqSync ^ reqPrev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            syncChain_q   <= '0;
            reqSyncDly_q  <= 1'b0;
            data_q        <= '0;
            state_q       <= IDLE;
            reqPrev_q     <= 1'b0;
            sample_q      <= '0;
            cnt_q         <= '0;
            outData_q     <= '0;
            outValid_q    <= 1'b0;
            ackToggle_q   <= 1'b0;
            errUnstable_q <= 1'b0;
            errOverrun_q  <= 1'b0;
            xferCount_q   <= '0;
        end else begin
            syncChain_q   <= {syncChain_q[SYNC_DEPTH-2:0], bus.req_async};
            reqSyncDly_q  <= reqSync;
            data_q        <= bus.data_async;
            state_q       <= state_d;
            reqPrev_q     <= reqPrev_d;
            sample_q      <= sample_d;
            cnt_q         <= cnt_d;
            outData_q     <= outData_d;
            outValid_q    <= outValid_d;
            ackToggle_q   <= ackToggle_d;
            errUnstable_q <= errUnstable_d;
            errOverrun_q  <= errOverrun_d;
            xferCount_q   <= xferCount_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        reqPrev_d     = reqPrev_q;
        sample_d      = sample_q;
        cnt_d         = cnt_q;
        outData_d     = outData_q;
        outValid_d    = outValid_q;
        ackToggle_d   = ackToggle_q;
        errUnstable_d = 1'b0;
        xferCount_d   = xferCount_q;
        // Any req movement while busy is a protocol violation by the sender; sticky until reset.
        errOverrun_d  = errOverrun_q | ((state_q != IDLE) & (reqSync ^ reqSyncDly_q));

        unique case (state_q)
            IDLE: begin
                if (reqEdge) begin
                    reqPrev_d = reqSync;
                    sample_d  = data_q;
                    cnt_d     = CNT_ONE;
                    if (STABLE_CYCLES == 1) begin
                        outData_d  = data_q;
                        outValid_d = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (data_q == sample_q) begin
                    if (cnt_q == CNT_LAST) begin
                        outData_d  = sample_q;
                        outValid_d = 1'b1;
                        state_d    = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    sample_d      = data_q;
                    cnt_d         = CNT_ONE;
                    errUnstable_d = 1'b1;
                end
            end
            HOLD: begin
                if (outValid_q && bus.out_ready) begin
                    outValid_d  = 1'b0;
                    ackToggle_d = ~ackToggle_q;
                    xferCount_d = xferCount_q + CNT_WIDTH'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack_toggle   = ackToggle_q;
    assign bus.out_data     = outData_q;
    assign bus.out_valid    = outValid_q;
    assign bus.err_unstable = errUnstable_q;
    assign bus.err_overrun  = errOverrun_q;
    assign bus.xfer_count   = xferCount_q;
endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Bench for cdc_handshake_rx: a default instance (A) and a STABLE_CYCLES=3 / CNT_WIDTH=4
// instance (B) share one sender and consumer, checked against transaction-level expectations.
module tb_cdc_handshake_rx;
    localparam int SYNC_DEPTH = 2;
    localparam int STABLE_A   = 2;
    localparam int STABLE_B   = 3;
    localparam int CNT_MOD_A  = 65536;
    localparam int CNT_MOD_B  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] data;
    logic        ready;

    int nCompared   = 0;
    int nMismatched = 0;
    int expCntA     = 0;
    int expCntB     = 0;
    int expOvr      = 0;
    int expUnstA    = 0;
    int expUnstB    = 0;
    int unstA       = 0;
    int unstB       = 0;

    cdc_handshake_rx_if #(.WIDTH(32), .CNT_WIDTH(16)) ifA ();
    cdc_handshake_rx_if #(.WIDTH(32), .CNT_WIDTH(4))  ifB ();

    assign ifA.req_async  = req;
    assign ifA.data_async = data;
    assign ifA.out_ready  = ready;
    assign ifB.req_async  = req;
    assign ifB.data_async = data;
    assign ifB.out_ready  = ready;

    cdc_handshake_rx #(.SYNC_DEPTH(SYNC_DEPTH), .WIDTH(32), .STABLE_CYCLES(STABLE_A), .CNT_WIDTH(16)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (ifA)
    );

    cdc_handshake_rx #(.SYNC_DEPTH(SYNC_DEPTH), .WIDTH(32), .STABLE_CYCLES(STABLE_B), .CNT_WIDTH(4)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (ifB)
    );

    always #5 clk = ~clk;

    // Count error pulses away from the active edge so each registered pulse is seen once.
    always @(negedge clk) begin
        if (ifA.err_unstable === 1'b1) unstA++;
        if (ifB.err_unstable === 1'b1) unstB++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Edges until valid: sync depth plus the stable window, restarted by a data change that
    // reaches the comparator before delivery (the change is seen by data_q one edge later).
    function automatic int expLat(input int stable, input int changeAt);
        int base;
        base = SYNC_DEPTH + stable;
        if (changeAt > 0 && changeAt + 2 <= base) return changeAt + 1 + stable;
        return base;
    endfunction

    task automatic checkStatus(input string phase);
        checkOutput({phase, ".ackA"},   32'(ifA.ack_toggle),  32'(expCntA % 2));
        checkOutput({phase, ".cntA"},   32'(ifA.xfer_count),  32'(expCntA % CNT_MOD_A));
        checkOutput({phase, ".validA"}, 32'(ifA.out_valid),   32'd0);
        checkOutput({phase, ".ovrA"},   32'(ifA.err_overrun), 32'(expOvr));
        checkOutput({phase, ".ackB"},   32'(ifB.ack_toggle),  32'(expCntB % 2));
        checkOutput({phase, ".cntB"},   32'(ifB.xfer_count),  32'(expCntB % CNT_MOD_B));
        checkOutput({phase, ".validB"}, 32'(ifB.out_valid),   32'd0);
        checkOutput({phase, ".ovrB"},   32'(ifB.err_overrun), 32'(expOvr));
        checkOutput({phase, ".unstA"},  32'(unstA),           32'(expUnstA));
        checkOutput({phase, ".unstB"},  32'(unstB),           32'(expUnstB));
    endtask

    // One transfer: optional fresh req toggle, optional data change during settling,
    // optional consumer backpressure and an optional extra req toggle while holding.
    task automatic applyStimulus(input logic [31:0] word, input int holdCycles, input int overrunAt,
                                 input bit fresh, input int changeAt, input logic [31:0] newWord);
        int latA, latB, n, wantLatA, wantLatB;
        logic [31:0] gotA, gotB, wantA, wantB;
        latA = -1;
        latB = -1;
        gotA = '0;
        gotB = '0;
        wantLatA = expLat(STABLE_A, changeAt);
        wantLatB = expLat(STABLE_B, changeAt);
        wantA = (wantLatA != SYNC_DEPTH + STABLE_A) ? newWord : word;
        wantB = (wantLatB != SYNC_DEPTH + STABLE_B) ? newWord : word;
        if (wantLatA != SYNC_DEPTH + STABLE_A) expUnstA++;
        if (wantLatB != SYNC_DEPTH + STABLE_B) expUnstB++;

        data  = word;
        ready = (holdCycles == 0);
        if (fresh) req = ~req;
        n = 0;
        while (n <= 16) begin
            if (latA < 0 && ifA.out_valid === 1'b1) begin latA = n; gotA = ifA.out_data; end
            if (latB < 0 && ifB.out_valid === 1'b1) begin latB = n; gotB = ifB.out_data; end
            if (latA >= 0 && latB >= 0) break;
            if (changeAt > 0 && n == changeAt) data = newWord;
            tick();
            n++;
        end
        if (fresh) begin
            checkOutput("latencyA", 32'(latA), 32'(wantLatA));
            checkOutput("latencyB", 32'(latB), 32'(wantLatB));
        end else begin
            checkOutput("pendingFoundA", 32'(latA >= 0), 32'd1);
            checkOutput("pendingFoundB", 32'(latB >= 0), 32'd1);
        end
        checkOutput("dataA", gotA, wantA);
        checkOutput("dataB", gotB, wantB);

        for (int i = 1; i <= holdCycles; i++) begin
            tick();
            checkOutput("holdValidA", 32'(ifA.out_valid),  32'd1);
            checkOutput("holdDataA",  ifA.out_data,        wantA);
            checkOutput("holdAckA",   32'(ifA.ack_toggle), 32'(expCntA % 2));
            if (i == overrunAt) begin
                req    = ~req;
                expOvr = 1;
            end
        end
        ready = 1'b1;
        tick();
        expCntA++;
        expCntB++;
        checkStatus("xfer");
    endtask

    initial begin
        logic [31:0] w;
        rst   = 1'b1;
        req   = 1'b0;
        data  = '0;
        ready = 1'b1;
        repeat (3) tick();
        checkOutput("resetValidA", 32'(ifA.out_valid), 32'd0);
        checkOutput("resetDataA",  ifA.out_data,       32'd0);
        checkOutput("resetDataB",  ifB.out_data,       32'd0);
        checkStatus("reset");
        rst = 1'b0;
        tick();

        $display("[TB] basic transfer");
        applyStimulus(32'hA5A5_0001, 0, 0, 1'b1, 0, '0);

        $display("[TB] backpressure");
        applyStimulus(32'h1234_5678, 10, 0, 1'b1, 0, '0);

        $display("[TB] unstable data during settling");
        applyStimulus(32'h0000_0001, 0, 0, 1'b1, 3, 32'h0000_0002);

        $display("[TB] overrun while holding, pending toggle served afterwards");
        w = $urandom;
        applyStimulus(w, 6, 2, 1'b1, 0, '0);
        applyStimulus(w, 0, 0, 1'b0, 0, '0);

        $display("[TB] randomized transfers");
        repeat (6) begin
            w = $urandom;
            applyStimulus(w, int'($urandom_range(0, 3)), 0, 1'b1, 0, '0);
        end

        $display("[TB] reset mid-settle");
        req = ~req;
        repeat (3) tick();
        rst = 1'b1;
        req = 1'b0;
        tick();
        rst     = 1'b0;
        expCntA = 0;
        expCntB = 0;
        expOvr  = 0;
        checkStatus("midReset");
        applyStimulus(32'hCAFE_0042, 0, 0, 1'b1, 0, '0);

        $display("[TB] counter wrap on the 4-bit instance");
        rst = 1'b1;
        req = 1'b0;
        tick();
        rst     = 1'b0;
        expCntA = 0;
        expCntB = 0;
        repeat (17) begin
            w = $urandom;
            applyStimulus(w, 0, 0, 1'b1, 0, '0);
        end
        checkOutput("wrapCntB", 32'(ifB.xfer_count), 32'd1);
        checkOutput("wrapAckB", 32'(ifB.ack_toggle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/cdc_handshake_rx.md
Name: cdc_handshake_rx

Overview:
- Receive-side controller for a toggle-based req/ack multi-bit clock-domain crossing.
- Owns a SYNC_DEPTH flop chain on the incoming request toggle and detects toggles on it.
- Qualifies the quasi-static data bus for stability, then presents the word on a valid/ready interface and returns an acknowledge toggle to the sender.
- Sits in the destination clock domain, between a remote-domain sender and local consumers.

Parameters:
SYNC_DEPTH, 2, flops in the req_async synchronizer chain; minimum 2.
WIDTH, 32, data bus width.
STABLE_CYCLES, 2, consecutive matching samples required before data is accepted; minimum 1.
CNT_WIDTH, 16, width of the transfer counter.

Ports:
clk  in  1  destination-domain clock.
rst  in  1  reset, synchronous to clk, active-high.
req_async  in  1  request toggle from sender domain; asynchronous to clk.
data_async  in  WIDTH  sender data; held stable by sender between its req toggle and ack receipt.
ack_toggle  out  1  acknowledge toggle back to sender; registered.
out_data  out  WIDTH  accepted word.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer accepts.
err_unstable  out  1  one-cycle pulse on a data mismatch during settling.
err_overrun  out  1  sticky flag: sender toggled req while a transfer was in progress.
xfer_count  out  CNT_WIDTH  completed transfers; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- Reset values: all outputs are 0, including out_data. Sync chain, req_prev, data_q, sample, counter and state are all 0; state = IDLE.
- Synchronizer:
  - req_async passes through SYNC_DEPTH flops; the last stage is req_sync.
  - data_async is registered once into data_q every cycle; no chain on data.
  - edge = req_sync XOR req_prev.
- IDLE:
  - If edge: req_prev <= req_sync, sample <= data_q, cnt <= 1.
  - If STABLE_CYCLES == 1, go directly to HOLD with out_data <= data_q and out_valid <= 1; otherwise go to SETTLE.
- SETTLE:
  - If data_q == sample and cnt == STABLE_CYCLES-1: out_data <= sample, out_valid <= 1, go to HOLD.
  - Else if data_q == sample: cnt <= cnt+1.
  - Else (mismatch): sample <= data_q, cnt <= 1, err_unstable pulses for one cycle, remain in SETTLE.
- HOLD:
  - out_valid is held at 1 and out_data is held constant until out_valid & out_ready.
  - On that cycle: out_valid <= 0, ack_toggle <= ~ack_toggle, xfer_count <= xfer_count+1, go to IDLE.
  - out_valid rises only on a state transition, never combinationally from out_ready.
- Latency:
  - From the first clk edge sampling a new req_async level to out_valid high: SYNC_DEPTH+STABLE_CYCLES edges (defaults: 4), with no mismatches.
  - ack_toggle changes on the edge that completes the valid/ready handshake.
  - The next transfer is accepted no earlier than the cycle after the return to IDLE.
- Overrun:
  - req_prev updates only on acceptance in IDLE.
  - When state != IDLE and req_sync differs from its value on the previous cycle, err_overrun is set; it clears only on rst.
  - A pending single toggle is processed when the FSM returns to IDLE.
  - A double toggle during busy cancels out; err_overrun still records it.
- Reset mid-transfer: returns to IDLE immediately, drops out_valid, no ack toggle issued, xfer_count cleared. The sender must be reset in step.
- xfer_count wraps from all-ones to 0 with no flag.

Test Plan:
- Basic transfer (defaults): hold data_async=0xA5A5_0001, toggle req_async 0->1, out_ready=1 -> out_valid high after 4 edges with out_data=0xA5A5_0001; ack_toggle=1 next edge; xfer_count=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_data=0x1234_5678 held all 10 cycles; ack_toggle unchanged until the cycle after out_ready=1.
- Unstable data, STABLE_CYCLES=3: change data_async 0x1->0x2 one cycle into SETTLE -> one err_unstable pulse; final out_data=0x2, delivered 3 stable samples after the change.
- Overrun: toggle req_async again while in HOLD -> err_overrun=1 and sticky; after the handshake completes, a second transfer starts from IDLE; xfer_count=2.
- Reset mid-SETTLE: assert rst for one cycle -> out_valid=0, ack_toggle=0, xfer_count=0; re-toggle req after reset -> normal 4-cycle delivery.
- Wrap with CNT_WIDTH=4: 17 back-to-back transfers -> xfer_count=1; ack_toggle=1 (odd count).
